alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/definitions_pkg.sv | 32 +++
 rtl/instr_fifo.sv | 72 +++++++
 rtl/alu_issue_stage.sv | 119 +++++++++++
 tb/tb_alu_issue_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/definitions_pkg.sv
// Shared ALU types: opcodes, operand signedness, data word, instruction word.
// Also hosts the optional issue counter width.
package definitions_pkg;

    typedef enum logic [2:0] {
        ADD,
        SUB,
        SL,
        SR,
        PASS_A
    } opcode_t;

    typedef enum logic {
        UNSIGNED,
        SIGNED
    } op_type_t;

    typedef union packed {
        logic signed [31:0] s_data;
        logic        [31:0] u_data;
    } data_t;

    typedef struct packed {
        opcode_t  opcode;
        op_type_t op_type;
        data_t    op_a;
        data_t    op_b;
    } instr_t;

    localparam int ISSUE_CNT_W = 16;

endpackage

// File: rtl/instr_fifo.sv
// Instruction queue for the ALU issue stage: DEPTH entries, registered head.
// Ports: clk, rst, push/push_data, pop, head, full, empty.
module instr_fifo
    import definitions_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  instr_t push_data,
    input  logic   pop,
    output instr_t head,
    output logic   full,
    output logic   empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    instr_t        mem_q [DEPTH];
    instr_t        mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            // Power-of-two depth: pointer wraps naturally.
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: queue -> registered iw -> external ALU -> registered result.
// Ports: clk, rst, in_valid/in_instr/in_ready, iw/iw_valid, alu_out,
// res_valid/res_data/res_ready; issue_cnt when ALU_ISSUE_CNT_EN is defined.
module alu_issue_stage
    import definitions_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    input  instr_t in_instr,
    output logic   in_ready,
    output instr_t iw,
    output logic   iw_valid,
    input  data_t  alu_out,
    output logic   res_valid,
    output data_t  res_data,
    input  logic   res_ready
`ifdef ALU_ISSUE_CNT_EN
    ,
    output logic [ISSUE_CNT_W-1:0] issue_cnt
`endif
);

    instr_t iw_q, iw_d;
    logic   iw_valid_q, iw_valid_d;
    data_t  res_data_q, res_data_d;
    logic   res_valid_q, res_valid_d;

    instr_t q_head;
    logic   q_full;
    logic   q_empty;
    logic   q_push;
    logic   q_pop;
    logic   advance;

    // in_ready is a pure function of occupancy; no path from res_ready.
    assign in_ready = !q_full;
    assign q_push   = in_valid && in_ready;
    assign advance  = !res_valid_q || res_ready;
    assign q_pop    = advance && !q_empty;

    instr_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (q_push),
        .push_data(in_instr),
        .pop      (q_pop),
        .head     (q_head),
        .full     (q_full),
        .empty    (q_empty)
    );

    always_comb begin
        iw_d        = iw_q;
        iw_valid_d  = iw_valid_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        if (advance) begin
            if (iw_valid_q) begin
                res_data_d  = alu_out;
                res_valid_d = 1'b1;
            end else if (res_ready) begin
                res_valid_d = 1'b0;
            end
            if (!q_empty) begin
                iw_d       = q_head;
                iw_valid_d = 1'b1;
            end else begin
                iw_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iw_q        <= '0;
            iw_valid_q  <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            iw_q        <= iw_d;
            iw_valid_q  <= iw_valid_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign iw        = iw_q;
    assign iw_valid  = iw_valid_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;

`ifdef ALU_ISSUE_CNT_EN
    logic [ISSUE_CNT_W-1:0] issue_cnt_q, issue_cnt_d;

    // Counts pops into iw; wraps at all-ones.
    always_comb begin
        issue_cnt_d = issue_cnt_q;
        if (q_pop) begin
            issue_cnt_d = issue_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign issue_cnt = issue_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage with a behavioural ALU.
// Counter test runs only when ALU_ISSUE_CNT_EN is defined.
module tb_alu_issue_stage;
    import definitions_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    logic   in_valid;
    instr_t in_instr;
    logic   in_ready;
    instr_t iw;
    logic   iw_valid;
    data_t  alu_out;
    logic   res_valid;
    data_t  res_data;
    logic   res_ready;
`ifdef ALU_ISSUE_CNT_EN
    logic [ISSUE_CNT_W-1:0] issue_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(
        .DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_instr (in_instr),
        .in_ready (in_ready),
        .iw       (iw),
        .iw_valid (iw_valid),
        .alu_out  (alu_out),
        .res_valid(res_valid),
        .res_data (res_data),
        .res_ready(res_ready)
`ifdef ALU_ISSUE_CNT_EN
        ,
        .issue_cnt(issue_cnt)
`endif
    );

    always_comb begin
        alu_out = '0;
        case (iw.opcode)
            ADD: alu_out.u_data = iw.op_a.u_data + iw.op_b.u_data;
            SUB: alu_out.u_data = iw.op_a.u_data - iw.op_b.u_data;
            SL:  alu_out.u_data = iw.op_a.u_data << iw.op_b.u_data[4:0];
            SR: begin
                if (iw.op_type == SIGNED)
                    alu_out.s_data = iw.op_a.s_data >>> iw.op_b.u_data[4:0];
                else
                    alu_out.u_data = iw.op_a.u_data >> iw.op_b.u_data[4:0];
            end
            default: alu_out = iw.op_a;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)",
                     tag, got, got, exp, exp);
        end
    endtask

    function automatic instr_t mk(input opcode_t op, input op_type_t ty,
                                  input logic [31:0] a, input logic [31:0] b);
        instr_t r;
        r.opcode       = op;
        r.op_type      = ty;
        r.op_a.u_data  = a;
        r.op_b.u_data  = b;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        res_ready = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        int  acc;
        int  got;
        int  sent;
        int  nlow;
        int  first;
        int  last;
        int  stale;
        logic take;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        res_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_iw_valid", 32'(iw_valid), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_iw_opa", iw.op_a.u_data, 32'd0);
        check("rst_res_data", res_data.u_data, 32'd0);

        // Signed shift right: -8 >>> 2 = -2, two-cycle latency
        res_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = mk(SR, SIGNED, 32'hFFFF_FFF8, 32'd2);
        tick();
        in_valid = 1'b0;
        check("sr_s_no_fallthru", 32'(iw_valid), 32'd0);
        tick();
        check("sr_s_iw_valid", 32'(iw_valid), 32'd1);
        check("sr_s_res_early", 32'(res_valid), 32'd0);
        tick();
        check("sr_s_res_valid", 32'(res_valid), 32'd1);
        check("sr_s_data", res_data.s_data, 32'hFFFF_FFFE);
        drain();

        // Unsigned shift right: 0xFFFFFFF8 >> 2 = 1073741822
        in_valid = 1'b1;
        in_instr = mk(SR, UNSIGNED, 32'hFFFF_FFF8, 32'd2);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("sr_u_res_valid", 32'(res_valid), 32'd1);
        check("sr_u_data", res_data.u_data, 32'd1073741822);
        drain();

        // Capacity under back-pressure: DEPTH+2 accepted
        res_ready = 1'b0;
        in_valid  = 1'b1;
        acc       = 0;
        for (int c = 0; c < 12; c++) begin
            in_instr = mk(ADD, UNSIGNED, 32'(acc), 32'd100);
            take     = in_ready;
            tick();
            if (take) acc++;
        end
        in_valid = 1'b0;
        check("cap_accepted", 32'(acc), 32'd6);
        check("cap_in_ready_low", 32'(in_ready), 32'd0);
        res_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            if (res_valid) begin
                check($sformatf("cap_res%0d", got), res_data.u_data,
                      32'(got + 100));
                got++;
            end
            tick();
        end
        check("cap_res_count", 32'(got), 32'd6);
        drain();

        // Back-to-back, full throughput
        got   = 0;
        sent  = 0;
        nlow  = 0;
        first = -1;
        last  = -1;
        for (int c = 0; c < 20; c++) begin
            if (res_valid) begin
                check($sformatf("b2b_res%0d", got), res_data.u_data,
                      32'(got + 200));
                if (first < 0) first = c;
                last = c;
                got++;
            end
            if (!in_ready) nlow++;
            if (sent < 8) begin
                in_valid = 1'b1;
                in_instr = mk(ADD, UNSIGNED, 32'(sent), 32'd200);
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        check("b2b_in_ready_low", 32'(nlow), 32'd0);
        check("b2b_res_count", 32'(got), 32'd8);
        check("b2b_span", 32'(last - first), 32'd7);
        drain();

        // Reset mid-operation with 3 queued, iw and res full
        res_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_instr = mk(ADD, UNSIGNED, 32'(c), 32'd300);
            tick();
        end
        check("mid_pre_res_valid", 32'(res_valid), 32'd1);
        check("mid_pre_iw_valid", 32'(iw_valid), 32'd1);
        rst      = 1'b1;
        in_instr = mk(ADD, UNSIGNED, 32'd99, 32'd0);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("mid_res_valid", 32'(res_valid), 32'd0);
        check("mid_iw_valid", 32'(iw_valid), 32'd0);
        check("mid_in_ready", 32'(in_ready), 32'd1);
        res_ready = 1'b1;
        stale     = 0;
        for (int c = 0; c < 6; c++) begin
            if (res_valid || iw_valid) stale++;
            tick();
        end
        check("mid_no_stale", 32'(stale), 32'd0);

`ifdef ALU_ISSUE_CNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("cnt_reset", 32'(issue_cnt), 32'd0);
        res_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = mk(ADD, UNSIGNED, 32'd1, 32'd1);
        acc       = 0;
        for (int c = 0; c < 70000 && acc < 65537; c++) begin
            take = in_ready;
            tick();
            if (take) acc++;
        end
        in_valid = 1'b0;
        check("cnt_pushed", 32'(acc), 32'd65537);
        repeat (3) tick();
        check("cnt_wrap", 32'(issue_cnt), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
